mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between the instruction-fetch requester (I) and the load/store requester (D) of the MIPS datapath.
- Sequences each memory transaction and returns read data with a one-cycle acknowledge.
- Raises per-requester stall signals for the pipeline control.
- Gives D priority, with anti-starvation for I and a memory-timeout error path.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_sat_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// No logic; pure declarations.
// Imported by the arbiter top.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_I = 3'd1,
      BUSY_D = 3'd2,
      RESP_I = 3'd3,
      RESP_D = 3'd4
   } arb_state_t;

   // Winner select used to steer the request fields onto the memory port
   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // Instruction fetches always read a whole word
   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear, used for starvation and timeout tracking.
// Latency: count updates one cycle after inc/clr; at_max is combinational from cnt.
// Backpressure: none; inc is ignored once the counter sits at MAX.
module arb_sat_counter #(
   parameter int MAX = 4,
   parameter int W   = (MAX < 2) ? 1 : $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         at_max
);

   assign at_max = (cnt == W'(MAX));

   // Count register: clear has priority over increment, holds at MAX
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_max) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D), D first with I anti-starvation.
// Latency: grant -> mem_req next cycle; mem_ready (or timeout) -> one-cycle ack the cycle after.
// Backpressure: requesters hold req until ack; stall_if/stall_d tell the pipeline to wait.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   output logic          if_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic [3:0]    d_be,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          d_err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall_if,
   output logic          stall_d
);

   localparam int SW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam int TW = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);

   arb_state_t    state;
   arb_state_t    next_state;

   logic          gnt_i;
   logic          gnt_d;
   logic          gnt_sel;
   logic          busy;
   logic          done;
   logic          done_i;
   logic          done_d;
   logic          timed_out;
   logic          starve_full;
   logic          to_last;

   logic [SW-1:0] starve_cnt;
   logic          starve_at_max;
   logic [TW-1:0] to_cnt;
   logic          to_at_max;

   assign starve_full = (starve_cnt == SW'(MAX_WAIT));
   assign to_last     = (to_cnt == TW'(TIMEOUT - 1));

   // Passed-over count for I: bumps on each D win while I waits, cleared when I wins
   arb_sat_counter #(.MAX(MAX_WAIT), .W(SW)) u_starve (
      .clk    (clk),
      .rst    (rst),
      .clr    (gnt_i),
      .inc    (gnt_d && if_req && !starve_at_max),
      .cnt    (starve_cnt),
      .at_max (starve_at_max)
   );

   // Cycles spent waiting on memory for the current transaction
   arb_sat_counter #(.MAX(TIMEOUT - 1), .W(TW)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (gnt_i || gnt_d),
      .inc    (busy && !to_at_max),
      .cnt    (to_cnt),
      .at_max (to_at_max)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: grant from IDLE, finish BUSY on ready or timeout, RESP always returns to IDLE
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (gnt_d) begin
               next_state = BUSY_D;
            end else if (gnt_i) begin
               next_state = BUSY_I;
            end
         end
         BUSY_I:  if (done) next_state = RESP_I;
         BUSY_D:  if (done) next_state = RESP_D;
         RESP_I:  next_state = IDLE;
         RESP_D:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Decode: grant arbitration and transaction completion; mem_ready beats a same-cycle timeout
   always_comb begin
      gnt_d     = (state == IDLE) && d_req && !(if_req && starve_full);
      gnt_i     = (state == IDLE) && if_req && !gnt_d;
      gnt_sel   = gnt_d ? GNT_D : GNT_I;
      busy      = (state == BUSY_I) || (state == BUSY_D);
      timed_out = busy && !mem_ready && to_last;
      done      = busy && (mem_ready || to_last);
      done_i    = done && (state == BUSY_I);
      done_d    = done && (state == BUSY_D);
   end

   // Memory-port and response registers; request fields latch only at grant
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_rdata  <= '0;
         if_ack    <= 1'b0;
         if_err    <= 1'b0;
         d_rdata   <= '0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         if (gnt_i || gnt_d) begin
            mem_addr  <= (gnt_sel == GNT_D) ? d_addr  : if_addr;
            mem_we    <= (gnt_sel == GNT_D) ? d_we    : 1'b0;
            mem_be    <= (gnt_sel == GNT_D) ? d_be    : BE_WORD;
            mem_wdata <= (gnt_sel == GNT_D) ? d_wdata : '0;
         end
         mem_req  <= (next_state == BUSY_I) || (next_state == BUSY_D);
         if_ack   <= done_i;
         if_err   <= done_i && timed_out;
         if_rdata <= (done_i && mem_ready) ? mem_rdata : '0;
         d_ack    <= done_d;
         d_err    <= done_d && timed_out;
         d_rdata  <= (done_d && mem_ready && !mem_we) ? mem_rdata : '0;
      end
   end

   assign stall_if = if_req && !if_ack;
   assign stall_d  = d_req && !d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences, random traffic.
// A transaction-level model predicts grants, memory-port contents and acks each cycle.
// Requester agents and a memory responder drive the DUT from queues.
module tb_mem_port_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int TIMEOUT  = 16;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_if;
   logic        stall_d;

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .if_err    (if_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .d_err     (d_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .stall_if  (stall_if),
      .stall_d   (stall_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          gap;
   } req_t;

   typedef struct {
      int          who;   // 1 = I, 2 = D
      logic [31:0] data;
      logic        err;
      int          cyc;
      logic        we;
      logic [3:0]  be;
   } rec_t;

   typedef struct {
      bit          use_i;
      bit          use_d;
      bit          d_we;
      logic [3:0]  d_be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mdata;
      int          lat;
      int          exp_n;
      int          exp_who;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_cyc;
      logic        exp_we;
      logic [3:0]  exp_be;
      int          exp_who2;
   } vec_t;

   req_t        iq[$];
   req_t        dq[$];
   rec_t        log_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          fixed_en = 1'b1;
   logic [31:0] fixed_data = 32'h0;
   bit          rand_lat = 1'b0;
   int          mem_lat = 1;
   int          m_mode = 0;   // 0 idle, 1 memory transaction in flight, 2 response cycle

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_mem(input logic [31:0] a);
      return fixed_en ? fixed_data : ((a * 32'h9E3779B1) ^ 32'h5A5A0000);
   endfunction

   // Memory responder: ready on the mem_lat-th cycle of mem_req (0 = never), noise elsewhere
   initial begin : responder
      int bc;
      bc = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req) bc++; else bc = 0;
         if (mem_req && mem_lat != 0 && bc == mem_lat) begin
            mem_ready = 1'b1;
            mem_rdata = exp_mem(mem_addr);
         end else begin
            mem_ready = !mem_req && rand_lat && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // Fetch requester
   initial begin : i_agent
      int   wt;
      req_t it;
      wt = 0;
      if_req = 1'b0;
      if_addr = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if_req = 1'b0;
            wt = 0;
         end else if (if_req) begin
            if (if_ack) begin
               if_req = 1'b0;
               wt = 0;
            end else begin
               wt++;
               if (wt > 300) begin
                  errors++;
                  $display("FAIL i_ack_wait: no if_ack after %0d cycles for addr %h", wt, if_addr);
                  if_req = 1'b0;
                  wt = 0;
               end
            end
         end else if (iq.size() > 0) begin
            if (iq[0].gap > 0) begin
               iq[0].gap = iq[0].gap - 1;
            end else begin
               it = iq.pop_front();
               if_addr = it.addr;
               if_req = 1'b1;
            end
         end
      end
   end

   // Load/store requester
   initial begin : d_agent
      int   wt;
      req_t it;
      wt = 0;
      d_req = 1'b0;
      d_we = 1'b0;
      d_addr = 32'h0;
      d_wdata = 32'h0;
      d_be = 4'h0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            d_req = 1'b0;
            wt = 0;
         end else if (d_req) begin
            if (d_ack) begin
               d_req = 1'b0;
               wt = 0;
            end else begin
               wt++;
               if (wt > 300) begin
                  errors++;
                  $display("FAIL d_ack_wait: no d_ack after %0d cycles for addr %h", wt, d_addr);
                  d_req = 1'b0;
                  wt = 0;
               end
            end
         end else if (dq.size() > 0) begin
            if (dq[0].gap > 0) begin
               dq[0].gap = dq[0].gap - 1;
            end else begin
               it = dq.pop_front();
               d_addr = it.addr;
               d_we = it.we;
               d_be = it.be;
               d_wdata = it.wdata;
               d_req = 1'b1;
            end
         end
      end
   end

   // Completion logger, independent of the model: records each ack with mem_req cycle count
   initial begin : logger
      int         lcyc;
      logic       lwe;
      logic [3:0] lbe;
      lcyc = 0;
      lwe = 1'b0;
      lbe = 4'h0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            lcyc = 0;
         end else begin
            if (mem_req) begin
               lcyc++;
               lwe = mem_we;
               lbe = mem_be;
            end
            if (if_ack) begin
               log_q.push_back('{1, if_rdata, if_err, lcyc, lwe, lbe});
               lcyc = 0;
            end
            if (d_ack) begin
               log_q.push_back('{2, d_rdata, d_err, lcyc, lwe, lbe});
               lcyc = 0;
            end
         end
      end
   end

   // Transaction-level reference: a grant costs 1 cycle, memory min(lat, TIMEOUT), response 1
   initial begin : model
      int          m_who;
      int          m_rem;
      int          m_starve;
      int          lat;
      logic        m_err;
      logic [31:0] m_data;
      logic [31:0] e_addr;
      logic        e_we;
      logic [3:0]  e_be;
      logic        gi;
      logic        gd;
      m_who = 0;
      m_rem = 0;
      m_starve = 0;
      m_err = 1'b0;
      m_data = 32'h0;
      e_addr = 32'h0;
      e_we = 1'b0;
      e_be = 4'h0;
      forever begin
         @(posedge clk);
         #1;
         chk("stall_if", stall_if, if_req & ~if_ack);
         chk("stall_d", stall_d, d_req & ~d_ack);
         if (!rst) begin
            m_mode = 0;
            m_starve = 0;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_be", mem_be, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_if_ack", if_ack, 0);
            chk("rst_if_err", if_err, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_d_ack", d_ack, 0);
            chk("rst_d_err", d_err, 0);
            chk("rst_d_rdata", d_rdata, 0);
         end else begin
            case (m_mode)
               0: begin
                  gd = d_req && !(if_req && m_starve == MAX_WAIT);
                  gi = !gd && if_req;
                  if (gd || gi) begin
                     if (rand_lat) begin
                        lat = $urandom_range(0, 19);
                        if (lat < 14) lat = lat % 5 + 1;
                        else if (lat < 16) lat = 0;
                        else if (lat == 16) lat = TIMEOUT;
                        else lat = TIMEOUT + 2;
                        mem_lat = lat;
                     end
                     lat = mem_lat;
                     m_err = (lat == 0) || (lat > TIMEOUT);
                     m_rem = m_err ? TIMEOUT : lat;
                     if (gd) begin
                        m_who = 2;
                        e_addr = d_addr;
                        e_we = d_we;
                        e_be = d_be;
                        if (if_req && m_starve < MAX_WAIT) m_starve++;
                        m_data = (m_err || d_we) ? 32'h0 : exp_mem(d_addr);
                        chk("grant_wdata", mem_wdata, d_wdata);
                     end else begin
                        m_who = 1;
                        e_addr = if_addr;
                        e_we = 1'b0;
                        e_be = 4'hF;
                        m_starve = 0;
                        m_data = m_err ? 32'h0 : exp_mem(if_addr);
                     end
                     chk("grant_mem_req", mem_req, 1);
                     chk("grant_addr", mem_addr, e_addr);
                     chk("grant_we", mem_we, e_we);
                     chk("grant_be", mem_be, e_be);
                     m_mode = 1;
                  end else begin
                     chk("idle_mem_req", mem_req, 0);
                  end
                  chk("idle_if_ack", if_ack, 0);
                  chk("idle_d_ack", d_ack, 0);
               end
               1: begin
                  m_rem--;
                  if (m_rem == 0) begin
                     chk("ack_mem_req", mem_req, 0);
                     chk("ack_if", if_ack, m_who == 1);
                     chk("ack_d", d_ack, m_who == 2);
                     if (m_who == 1) begin
                        chk("ack_if_rdata", if_rdata, m_data);
                        chk("ack_if_err", if_err, m_err);
                     end else begin
                        chk("ack_d_rdata", d_rdata, m_data);
                        chk("ack_d_err", d_err, m_err);
                     end
                     m_mode = 2;
                  end else begin
                     chk("busy_mem_req", mem_req, 1);
                     chk("busy_addr", mem_addr, e_addr);
                     chk("busy_we", mem_we, e_we);
                     chk("busy_be", mem_be, e_be);
                     chk("busy_if_ack", if_ack, 0);
                     chk("busy_d_ack", d_ack, 0);
                  end
               end
               default: begin
                  chk("post_if_ack", if_ack, 0);
                  chk("post_d_ack", d_ack, 0);
                  chk("post_mem_req", mem_req, 0);
                  m_mode = 0;
               end
            endcase
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (!(iq.size() == 0 && dq.size() == 0 && !if_req && !d_req && m_mode == 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_drain: traffic still pending after %0d cycles", name, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl[6];
   int   order_exp[6];

   initial begin : main
      int n;
      tbl[0] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h00400000, 32'h0, 32'h8C220004, 2,
                 1, 1, 32'h8C220004, 1'b0, 2, 1'b0, 4'hF, 0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10010008, 32'h0, 32'hDEADBEEF, 3,
                 2, 2, 32'hDEADBEEF, 1'b0, 3, 1'b0, 4'hF, 1};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 4'b0010, 32'h10010009, 32'h0000AB00, 32'h12345678, 1,
                 1, 2, 32'h0, 1'b0, 1, 1'b1, 4'b0010, 0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h10010010, 32'h0, 32'hCAFEF00D, 0,
                 1, 2, 32'h0, 1'b1, 16, 1'b0, 4'hF, 0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h10010014, 32'h0, 32'h0BADC0DE, 16,
                 1, 2, 32'h0BADC0DE, 1'b0, 16, 1'b0, 4'hF, 0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h00400004, 32'h0, 32'h11111111, 20,
                 1, 1, 32'h0, 1'b1, 16, 1'b0, 4'hF, 0};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Directed vector table
      for (int r = 0; r < 6; r++) begin
         log_q.delete();
         fixed_data = tbl[r].mdata;
         mem_lat = tbl[r].lat;
         if (tbl[r].use_i) iq.push_back('{tbl[r].addr, 1'b0, 4'hF, 32'h0, 0});
         if (tbl[r].use_d) dq.push_back('{tbl[r].addr, tbl[r].d_we, tbl[r].d_be, tbl[r].wdata, 0});
         wait_drain($sformatf("row%0d", r), 400);
         chk($sformatf("row%0d_count", r), log_q.size(), tbl[r].exp_n);
         if (log_q.size() >= 1) begin
            chk($sformatf("row%0d_who", r), log_q[0].who, tbl[r].exp_who);
            chk($sformatf("row%0d_rdata", r), log_q[0].data, tbl[r].exp_data);
            chk($sformatf("row%0d_err", r), log_q[0].err, tbl[r].exp_err);
            chk($sformatf("row%0d_req_cycles", r), log_q[0].cyc, tbl[r].exp_cyc);
            chk($sformatf("row%0d_we", r), log_q[0].we, tbl[r].exp_we);
            chk($sformatf("row%0d_be", r), log_q[0].be, tbl[r].exp_be);
         end
         if (tbl[r].exp_n == 2 && log_q.size() >= 2) begin
            chk($sformatf("row%0d_who2", r), log_q[1].who, tbl[r].exp_who2);
         end
      end

      // Starvation: D keeps issuing stores while I waits; I must win the fifth grant
      log_q.delete();
      mem_lat = 1;
      fixed_data = 32'h0;
      for (int k = 0; k < 5; k++) dq.push_back('{32'h10020000 + 32'(4 * k), 1'b1, 4'hF, 32'(k), 0});
      iq.push_back('{32'h00400100, 1'b0, 4'hF, 32'h0, 0});
      order_exp = '{2, 2, 2, 2, 1, 2};
      wait_drain("starve", 600);
      chk("starve_count", log_q.size(), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < log_q.size()) chk($sformatf("starve_order%0d", k), log_q[k].who, order_exp[k]);
      end

      // Reset during BUSY_D with starvation counter saturated
      log_q.delete();
      mem_lat = 3;
      fixed_data = 32'h600DF00D;
      for (int k = 0; k < 4; k++) dq.push_back('{32'h10030000 + 32'(4 * k), 1'b0, 4'hF, 32'h0, 0});
      iq.push_back('{32'h00400200, 1'b0, 4'hF, 32'h0, 0});
      n = 0;
      while (log_q.size() < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rstseq_busy_reached", mem_req, 1);
      rst = 1'b0;
      iq.delete();
      dq.delete();
      @(negedge clk);
      chk("rstseq_mem_req", mem_req, 0);
      chk("rstseq_d_ack", d_ack, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstseq_no_ack", log_q.size(), 3);
      log_q.delete();
      iq.push_back('{32'h00400300, 1'b0, 4'hF, 32'h0, 0});
      dq.push_back('{32'h10040000, 1'b0, 4'hF, 32'h0, 0});
      wait_drain("rstseq_after", 400);
      chk("rstseq_after_count", log_q.size(), 2);
      if (log_q.size() >= 2) begin
         chk("rstseq_after_first", log_q[0].who, 2);
         chk("rstseq_after_second", log_q[1].who, 1);
         chk("rstseq_after_i_rdata", log_q[1].data, 32'h600DF00D);
         chk("rstseq_after_i_err", log_q[1].err, 0);
      end

      // Random traffic against the model
      fixed_en = 1'b0;
      rand_lat = 1'b1;
      for (int k = 0; k < 150; k++) begin
         iq.push_back('{$urandom & 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, int'($urandom_range(0, 4))});
         dq.push_back('{$urandom, 1'($urandom_range(0, 2) == 0), 4'($urandom_range(1, 15)),
                        $urandom, int'($urandom_range(0, 4))});
      end
      wait_drain("random", 30000);
      rand_lat = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
